rx_slicer_deser: RTL and testbench
==================================

RX_SLICER_DESER -- requirements
Module: rx_slicer_deser

Interface
REQ-001 Parameter IN_WIDTH, default 18: width of the signed filter-output sample.
REQ-002 Parameter WORD_WIDTH, default 8: deserialized word width, legal range 2..32.
REQ-003 Parameter LOCK_GOOD, default 16: consecutive PRBS-correct bits required to declare lock, legal range 1..255.
REQ-004 Parameter LOSS_BAD, default 8: consecutive PRBS errors that drop lock, legal range 1..255.
REQ-005 Port: clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-006 Port: rst, input, 1, asynchronous, active-low reset.
REQ-007 Port: in, input, IN_WIDTH, signed two's-complement filter output.
REQ-008 Port: sample_en, input, 1, one-cycle strobe marking the RX sampling instant.
REQ-009 Port: thresh, input, IN_WIDTH, signed slicing threshold.
REQ-010 Port: bit_out, output, 1, last sliced bit.
REQ-011 Port: bit_valid, output, 1, one-cycle pulse when bit_out updates.
REQ-012 Port: word_out, output, WORD_WIDTH, deserialized word.
REQ-013 Port: word_valid, output, 1, word_out holds an unconsumed word.
REQ-014 Port: word_ready, input, 1, consumer accepts word_out.
REQ-015 Port: overflow, output, 1, sticky flag set when a completed word is dropped.
REQ-016 Port: locked, output, 1, PRBS7 checker is in the LOCKED state.
REQ-017 Port: err_count, output, 16, saturating count of PRBS errors seen while locked.

Function
REQ-018 Slicing: the sliced bit is 1 when signed in >= signed thresh, otherwise 0, evaluated in the cycle sample_en=1.
REQ-019 Latency: bit_out and bit_valid update on the edge that samples sample_en=1; bit_valid is high exactly one cycle per strobe.
REQ-020 Back-to-back sample_en on consecutive cycles: every strobe produces one bit, with no loss.
REQ-021 Deserializer: bits pack LSB-first, so the first bit after reset or after word completion goes to bit 0 of the word.
REQ-022 A bit counter runs 0..WORD_WIDTH-1 and wraps to 0 on the bit that completes the word.
REQ-023 The completed word loads word_out, and sets word_valid, on the same edge that registers its last bit.
REQ-024 Handshake: a word transfers on any edge where word_valid=1 and word_ready=1; if no new word completes on that edge, word_valid clears.
REQ-025 Simultaneous transfer and completion: the new word loads, word_valid stays 1, and overflow is not set.
REQ-026 Completion while word_valid=1 and word_ready=0: the new word is dropped, word_out holds its value, and overflow sets and stays set until reset.
REQ-027 word_out is stable while word_valid=1 and word_ready=0.
REQ-028 PRBS7 (x^7+x^6+1) self-synchronising checker: the predicted bit is h[6] XOR h[5], where h is the 7-bit history of prior sliced bits and h[0] is the newest.
REQ-029 An error is counted only when the history holds 7 valid bits.
REQ-030 FSM state SEARCH, reset state: a good-bit counter increments on each correct bit and clears on each error; reaching LOCK_GOOD moves the FSM to LOCKED and clears the counter.
REQ-031 FSM state LOCKED: each error increments err_count (saturating at 0xFFFF) and a bad-bit counter; a correct bit clears the bad-bit counter.
REQ-032 In LOCKED, reaching LOSS_BAD consecutive errors moves the FSM to SEARCH; err_count is held, not cleared.
REQ-033 The FSM and counters advance only on strobed bits; locked reflects the state register.
REQ-034 Reset mid-word discards the partial word; the bit counter returns to 0.

Reset
REQ-035 With rst=0: bit_out=0, bit_valid=0, word_out=0, word_valid=0, overflow=0, locked=0, err_count=0, bit counter=0, history-valid count=0, FSM=SEARCH, good and bad counters=0.
REQ-036 Reset assertion acts immediately without waiting for a clock edge; release is sampled on the next clk edge.

Verification
REQ-037 thresh=0; in=-1, 0, +5 each with sample_en -> bit_out=0, 1, 1, each one cycle after its strobe.
REQ-038 WORD_WIDTH=8; bits 1,0,1,1,0,0,0,0 with word_ready=1 -> word_out=8'h0D, word_valid high for exactly one cycle.
REQ-039 word_ready=0; two full words 8'h0D then 8'h55 -> word_out stays 8'h0D and overflow=1; then word_ready=1 -> word_valid clears.
REQ-040 Clean PRBS7 stream -> locked rises after 7+16 bits; inject 3 single errors -> err_count=3 and locked stays 1.
REQ-041 While locked, drive 8 consecutive bit errors -> locked=0 and err_count=8 (plus earlier errors); a clean stream relocks after 16 further correct bits.
REQ-042 Assert rst after 5 bits of a word -> all outputs return to reset values; the next 8 bits form a complete fresh word.

Source files
------------

// File: rtl/rx_slicer_deser.sv
// ============================================================================
// Module   : rx_slicer_deser
// Brief    : Slices a signed filter output against a threshold on each RX
//            sampling strobe, packs the bits LSB-first into words with a
//            valid/ready output, and checks the bit stream against a
//            self-synchronising PRBS7 (x^7+x^6+1) pattern with lock tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_slicer_deser #(
  parameter int IN_WIDTH   = 18,
  parameter int WORD_WIDTH = 8,
  parameter int LOCK_GOOD  = 16,
  parameter int LOSS_BAD   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] in,
  input  logic                       sample_en,
  input  logic signed [IN_WIDTH-1:0] thresh,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic [WORD_WIDTH-1:0]      word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       overflow,
  output logic                       locked,
  output logic [15:0]                err_count
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_WIDTH - 1);
  localparam logic [7:0]       GOOD_LAST = 8'(LOCK_GOOD - 1);
  localparam logic [7:0]       BAD_LAST  = 8'(LOSS_BAD - 1);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Slicer / deserializer state
  logic                  slice_bit;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] acc;
  logic [WORD_WIDTH-1:0] acc_next;
  logic                  word_done;

  // PRBS checker state
  logic [6:0]            hist;
  logic [2:0]            hist_cnt;
  logic                  check_en;
  logic                  bit_err;
  state_t                state;
  logic [7:0]            good_cnt;
  logic [7:0]            bad_cnt;

  // Both operands are declared signed, so this is a two's-complement compare
  assign slice_bit = (in >= thresh);

  // The word being completed includes the bit arriving this cycle
  always_comb begin
    acc_next          = acc;
    acc_next[bit_cnt] = slice_bit;
  end

  assign word_done = sample_en && (bit_cnt == LAST_BIT);

  // Predicted bit comes from taps 7 and 6 bits back; only trusted once full
  assign check_en = sample_en && (hist_cnt == 3'd7);
  assign bit_err  = slice_bit ^ (hist[6] ^ hist[5]);
  assign locked   = (state == LOCKED);

  // Register the sliced bit and pack it into the word accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_cnt   <= '0;
      acc       <= '0;
    end else begin
      bit_valid <= sample_en;
      if (sample_en) begin
        bit_out <= slice_bit;
        acc     <= acc_next;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Output word handshake; a completion that cannot be held is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (word_done) begin
        if (!word_valid || word_ready) begin
          word_out   <= acc_next;
          word_valid <= 1'b1;
        end else begin
          overflow   <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

  // Shift received bits into the PRBS history and count until it is full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= '0;
      hist_cnt <= '0;
    end else if (sample_en) begin
      hist <= {hist[5:0], slice_bit};
      if (hist_cnt != 3'd7) begin
        hist_cnt <= hist_cnt + 3'd1;
      end
    end
  end

  // Lock FSM: runs of good bits acquire lock, runs of bad bits lose it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      err_count <= '0;
    end else if (check_en) begin
      case (state)
        SEARCH: begin
          if (bit_err) begin
            good_cnt <= '0;
          end else if (good_cnt == GOOD_LAST) begin
            good_cnt <= '0;
            state    <= LOCKED;
          end else begin
            good_cnt <= good_cnt + 8'd1;
          end
        end
        LOCKED: begin
          if (bit_err) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            if (bad_cnt == BAD_LAST) begin
              bad_cnt <= '0;
              state   <= SEARCH;
            end else begin
              bad_cnt <= bad_cnt + 8'd1;
            end
          end else begin
            bad_cnt <= '0;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_slicer_deser.sv
// ============================================================================
// Module   : tb_rx_slicer_deser
// Brief    : Directed bench for rx_slicer_deser with a bit-history model of
//            the slicer, word packer and PRBS7 lock behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_slicer_deser;

  localparam int IW = 18;
  localparam int WW = 8;
  localparam int LG = 16;
  localparam int LB = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [IW-1:0] in_s = '0;
  logic signed [IW-1:0] thresh = '0;
  logic                 sample_en = 1'b0;
  logic                 word_ready = 1'b0;
  logic                 bit_out;
  logic                 bit_valid;
  logic [WW-1:0]        word_out;
  logic                 word_valid;
  logic                 overflow;
  logic                 locked;
  logic [15:0]          err_count;

  rx_slicer_deser #(
    .IN_WIDTH(IW), .WORD_WIDTH(WW), .LOCK_GOOD(LG), .LOSS_BAD(LB)
  ) dut (
    .clk(clk), .rst(rst), .in(in_s), .sample_en(sample_en), .thresh(thresh),
    .bit_out(bit_out), .bit_valid(bit_valid), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .overflow(overflow),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: every bit received since reset plus derived output state
  bit            rxq[$];
  bit            txq[$];
  bit            m_bit_out, m_bit_valid, m_wv, m_ov, m_locked;
  logic [WW-1:0] m_word;
  int            m_err, m_good, m_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    m_bit_out = 0; m_bit_valid = 0; m_wv = 0; m_ov = 0; m_locked = 0;
    m_word = '0; m_err = 0; m_good = 0; m_bad = 0;
  endtask

  task automatic model_prbs(input bit err);
    if (!m_locked) begin
      if (err) m_good = 0;
      else begin
        m_good++;
        if (m_good == LG) begin m_locked = 1; m_good = 0; end
      end
    end else if (err) begin
      if (m_err < 65535) m_err++;
      m_bad++;
      if (m_bad == LB) begin m_locked = 0; m_bad = 0; end
    end else begin
      m_bad = 0;
    end
  endtask

  task automatic model_step();
    bit b;
    bit done;
    int n;
    logic [WW-1:0] w;
    done = 0;
    m_bit_valid = sample_en;
    if (sample_en) begin
      b = (in_s >= thresh);
      m_bit_out = b;
      rxq.push_back(b);
      n = rxq.size();
      done = (n % WW) == 0;
      if (n > 7) model_prbs(b != (rxq[n-8] ^ rxq[n-7]));
      if (done) for (int i = 0; i < WW; i++) w[i] = rxq[n-WW+i];
    end
    if (done) begin
      if (!m_wv || word_ready) begin m_word = w; m_wv = 1; end
      else m_ov = 1;
    end else if (m_wv && word_ready) begin
      m_wv = 0;
    end
  endtask

  task automatic compare();
    check("bit_out", bit_out, m_bit_out);
    check("bit_valid", bit_valid, m_bit_valid);
    check("word_out", word_out, m_word);
    check("word_valid", word_valid, m_wv);
    check("overflow", overflow, m_ov);
    check("locked", locked, m_locked);
    check("err_count", err_count, m_err);
  endtask

  // One clock: drive at negedge, model on posedge, compare just after
  task automatic cyc(input bit se, input logic signed [IW-1:0] din, input logic signed [IW-1:0] th);
    sample_en = se; in_s = din; thresh = th;
    @(posedge clk);
    if (rst) model_step();
    #1 compare();
    @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input int gap);
    cyc(1'b1, b ? 18'sd5 : -18'sd5, 18'sd0);
    repeat (gap) cyc(1'b0, 18'sd0, 18'sd0);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) send_bit(w[i], gap);
  endtask

  // Asynchronous assert mid-cycle, release at a negedge
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    txq.delete();
    sample_en = 1'b0;
    #1 compare();
    @(posedge clk); #1 compare();
    @(negedge clk) rst = 1'b1;
  endtask

  function automatic bit next_clean();
    int n;
    n = txq.size();
    return txq[n-7] ^ txq[n-6];
  endfunction

  task automatic tx_bit(input bit b);
    txq.push_back(b);
    send_bit(b, 0);
  endtask

  task automatic prbs_clean(input int k);
    repeat (k) tx_bit(next_clean());
  endtask

  task automatic prbs_err(input int k);
    repeat (k) tx_bit(!next_clean());
  endtask

  initial begin
    model_reset();
    repeat (2) begin @(negedge clk); compare(); end
    rst = 1'b1;

    // Slicer against zero threshold, back-to-back strobes
    word_ready = 1'b1;
    cyc(1'b1, -18'sd1, 18'sd0); check("slice_m1", bit_out, 0);
    cyc(1'b1,  18'sd0, 18'sd0); check("slice_0", bit_out, 1);
    cyc(1'b1,  18'sd5, 18'sd0); check("slice_p5", bit_out, 1);
    cyc(1'b0,  18'sd0, 18'sd0); check("bit_valid_drop", bit_valid, 0);
    cyc(1'b1, -18'sd100, -18'sd99);
    cyc(1'b1, -18'sd99, -18'sd99); check("slice_neg_eq", bit_out, 1);

    // Basic word assembly with ready high
    do_reset();
    send_word(8'h0D, 8, 1);
    check("w0D_data", word_out, 8'h0D);
    check("w0D_valid_hold_after_gap", word_valid, 0);

    // Simultaneous transfer and completion keeps valid, no overflow
    word_ready = 1'b0;
    send_word(8'hA5, 8, 0);
    check("wA5_data", word_out, 8'hA5);
    send_word(8'h3C, 7, 0);
    check("hold_stable", word_out, 8'hA5);
    word_ready = 1'b1;
    send_bit(1'b0, 0);
    check("w3C_data", word_out, 8'h3C);
    check("w3C_valid", word_valid, 1);
    check("w3C_no_ovf", overflow, 0);
    cyc(1'b0, 18'sd0, 18'sd0);
    check("w3C_cleared", word_valid, 0);

    // Overflow: second word dropped while first is held
    word_ready = 1'b0;
    send_word(8'h0D, 8, 0);
    send_word(8'h55, 8, 1);
    check("ovf_keep", word_out, 8'h0D);
    check("ovf_set", overflow, 1);
    word_ready = 1'b1;
    cyc(1'b0, 18'sd0, 18'sd0);
    check("ovf_drain", word_valid, 0);
    check("ovf_sticky", overflow, 1);

    // PRBS7 lock acquisition and isolated errors
    do_reset();
    for (int i = 0; i < 7; i++) tx_bit(i == 0);
    prbs_clean(15);
    check("lock_22", locked, 0);
    prbs_clean(1);
    check("lock_23", locked, 1);
    repeat (3) begin prbs_clean(10); prbs_err(1); end
    prbs_clean(4);
    check("err3", err_count, 3);
    check("lock_after_err3", locked, 1);

    // Loss of lock, held error count, relock
    prbs_err(7);
    check("lock_bad7", locked, 1);
    prbs_err(1);
    check("lock_bad8", locked, 0);
    check("err11", err_count, 11);
    prbs_clean(15);
    check("relock_15", locked, 0);
    prbs_clean(1);
    check("relock_16", locked, 1);
    check("err_held", err_count, 11);

    // Reset mid-word discards the partial word
    send_word(8'hFF, 5, 0);
    #2 rst = 1'b0;
    model_reset();
    txq.delete();
    sample_en = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_err", err_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_bit", bit_out, 0);
    @(posedge clk); #1 compare();
    @(negedge clk) rst = 1'b1;
    send_word(8'h96, 8, 0);
    check("fresh_word", word_out, 8'h96);
    check("fresh_valid", word_valid, 1);
    cyc(1'b0, 18'sd0, 18'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
